// File: rtl/wb_clkdiv_ctrl_if.sv
// Wishbone bus between the AHB-to-FPGA bridge (master) and fabric register blocks (slave).
interface wb_clkdiv_ctrl_if #(
    parameter int unsigned ADR_W = 17
) ();
    logic [ADR_W-1:0] WBs_ADR;
    logic             WBs_CYC;
    logic             WBs_STB;
    logic             WBs_WE;
    logic             WBs_RD;
    logic [3:0]       WBs_BYTE_STB;
    logic [31:0]      WBs_WR_DAT;
    logic [31:0]      WBs_RD_DAT;
    logic             WBs_ACK;

    modport master (
        output WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB, WBs_WR_DAT,
        input  WBs_RD_DAT, WBs_ACK
    );

    modport slave (
        input  WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB, WBs_WR_DAT,
        output WBs_RD_DAT, WBs_ACK
    );
endinterface

// File: rtl/wb_clkdiv_ctrl.sv
// Wishbone register block driving a programmable clock-enable divider with tick counter,
// sticky tick status and level interrupt; every access is acknowledged after one wait state.
module wb_clkdiv_ctrl #(
    parameter logic [15:0] DEVICE_ID = 16'hABCD,
    parameter logic [15:0] DIV_RST   = 16'd3,
    parameter int unsigned ADR_W     = 17
) (
    input  logic            clk1,
    input  logic            WB_RST_FPGA,
    wb_clkdiv_ctrl_if.slave wb,
    output logic            tick_o,
    output logic            div_en_o,
    output logic            irq_o
);
    localparam logic [2:0] AdrId     = 3'd0;
    localparam logic [2:0] AdrCtrl   = 3'd1;
    localparam logic [2:0] AdrDiv    = 3'd2;
    localparam logic [2:0] AdrStatus = 3'd3;
    localparam logic [2:0] AdrTckCnt = 3'd4;
    localparam logic [2:0] AdrScr    = 3'd5;

    logic        ack_q;
    logic [31:0] rd_dat_q, rd_dat_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tick_q, tick_d;
    logic        seen_q, seen_d;
    logic        irq_q;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic [31:0] scratch_q, scratch_d;

    logic        req, wr, div_wr;
    logic [2:0]  adr;
    logic [3:0]  be;
    logic [31:0] wdat;

    // Address bits outside [4:2] and the RD hint are not needed for decode.
    logic unused_ok;
    assign unused_ok = ^{wb.WBs_ADR[ADR_W-1:5], wb.WBs_ADR[1:0], wb.WBs_RD};

    assign adr    = wb.WBs_ADR[4:2];
    assign be     = wb.WBs_BYTE_STB;
    assign wdat   = wb.WBs_WR_DAT;
    assign req    = wb.WBs_CYC & wb.WBs_STB & ~ack_q;
    assign wr     = req & wb.WBs_WE;
    assign div_wr = wr && (adr == AdrDiv) && (be[1:0] != 2'b00);

    always_comb begin
        rd_dat_d   = '0;
        ctrl_d     = ctrl_q;
        div_d      = div_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        tick_d     = 1'b0;
        tick_cnt_d = tick_cnt_q;
        seen_d     = seen_q;

        if (req && !wb.WBs_WE) begin
            unique case (adr)
                AdrId:     rd_dat_d = {16'h0, DEVICE_ID};
                AdrCtrl:   rd_dat_d = {30'h0, ctrl_q};
                AdrDiv:    rd_dat_d = {16'h0, div_q};
                AdrStatus: rd_dat_d = {31'h0, seen_q};
                AdrTckCnt: rd_dat_d = tick_cnt_q;
                AdrScr:    rd_dat_d = scratch_q;
                default:   rd_dat_d = '0;
            endcase
        end

        if (wr && (adr == AdrCtrl) && be[0]) ctrl_d = wdat[1:0];
        if (wr && (adr == AdrDiv)) begin
            if (be[0]) div_d[7:0]  = wdat[7:0];
            if (be[1]) div_d[15:8] = wdat[15:8];
        end
        if (wr && (adr == AdrScr)) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) scratch_d[8*i +: 8] = wdat[8*i +: 8];
            end
        end

        // A DIV write restarts the period and swallows a tick due on the same edge.
        if (!ctrl_q[0] || div_wr) begin
            cnt_d = '0;
        end else if (cnt_q == div_q) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        if (wr && (adr == AdrTckCnt) && be[0]) tick_cnt_d = '0;
        else if (tick_q)                       tick_cnt_d = tick_cnt_q + 32'd1;

        if (tick_q)                                           seen_d = 1'b1;
        else if (wr && (adr == AdrStatus) && be[0] && wdat[0]) seen_d = 1'b0;
    end

    always_ff @(posedge clk1 or posedge WB_RST_FPGA) begin
        if (WB_RST_FPGA) begin
            ack_q      <= 1'b0;
            rd_dat_q   <= '0;
            ctrl_q     <= '0;
            div_q      <= DIV_RST;
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            seen_q     <= 1'b0;
            irq_q      <= 1'b0;
            tick_cnt_q <= '0;
            scratch_q  <= '0;
        end else begin
            ack_q      <= req;
            rd_dat_q   <= rd_dat_d;
            ctrl_q     <= ctrl_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            seen_q     <= seen_d;
            irq_q      <= ctrl_q[1] & seen_q;
            tick_cnt_q <= tick_cnt_d;
            scratch_q  <= scratch_d;
        end
    end

    assign wb.WBs_ACK    = ack_q;
    assign wb.WBs_RD_DAT = rd_dat_q;
    assign tick_o        = tick_q;
    assign div_en_o      = ctrl_q[0];
    assign irq_o         = irq_q;
endmodule

// File: tb/tb_wb_clkdiv_ctrl.sv
// Bench for wb_clkdiv_ctrl: directed scenarios plus random bus traffic, compared each cycle
// against a behavioural model that predicts ticks from the edge distance to the last restart.
module tb_wb_clkdiv_ctrl;
    logic clk1 = 1'b0;
    logic rst  = 1'b0;
    always #5 clk1 = ~clk1;

    wb_clkdiv_ctrl_if #(.ADR_W(17)) bus ();
    logic tick, div_en, irq;

    wb_clkdiv_ctrl #(
        .DEVICE_ID(16'hABCD),
        .DIV_RST  (16'd3),
        .ADR_W    (17)
    ) dut (
        .clk1       (clk1),
        .WB_RST_FPGA(rst),
        .wb         (bus),
        .tick_o     (tick),
        .div_en_o   (div_en),
        .irq_o      (irq)
    );

    int checks   = 0;
    int failures = 0;
    bit run      = 1'b0;
    int force_seq  = 0;
    int force_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 32'h%08h, expected 32'h%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_ack, m_tick, m_irq, m_seen;
    logic [31:0] m_rd, m_tcnt, m_scr;
    logic [1:0]  m_ctrl;
    logic [15:0] m_div;
    longint      m_edge, m_anchor;

    bit          t_req, t_wr, t_divwr, t_tick;
    logic [2:0]  t_a;
    logic [3:0]  t_be;
    logic [31:0] t_d, t_tcnt;

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'h0000_ABCD;
            3'd1:    return {30'h0, m_ctrl};
            3'd2:    return {16'h0, m_div};
            3'd3:    return {31'h0, m_seen};
            3'd4:    return m_tcnt;
            3'd5:    return m_scr;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk1 or posedge rst) begin
        if (rst) begin
            m_ack = 0; m_rd = 0; m_tick = 0; m_irq = 0; m_seen = 0;
            m_ctrl = 0; m_div = 16'd3; m_tcnt = 0; m_scr = 0;
            m_edge = 0; m_anchor = 0;
        end else begin
            m_edge++;
            t_req   = bus.WBs_CYC && bus.WBs_STB && !m_ack;
            t_wr    = t_req && bus.WBs_WE;
            t_a     = bus.WBs_ADR[4:2];
            t_be    = bus.WBs_BYTE_STB;
            t_d     = bus.WBs_WR_DAT;
            t_divwr = t_wr && (t_a == 3'd2) && (t_be[1:0] != 0);
            t_tcnt  = m_tcnt;
            if (force_seq != force_seen) begin
                t_tcnt     = 32'hFFFF_FFFF;
                force_seen = force_seq;
            end
            // Ticks land every N+1 edges after the last restart (disabled edge or DIV write).
            t_tick = m_ctrl[0] && !t_divwr &&
                     (((m_edge - m_anchor) % (longint'(m_div) + 1)) == 0);
            if (!m_ctrl[0] || t_divwr) m_anchor = m_edge;

            m_rd  = (t_req && !bus.WBs_WE) ? m_read(t_a) : 32'h0;
            m_irq = m_ctrl[1] && m_seen;
            if (t_wr && t_a == 3'd4 && t_be[0]) m_tcnt = 0;
            else                                m_tcnt = t_tcnt + (m_tick ? 1 : 0);
            if (m_tick)                                      m_seen = 1;
            else if (t_wr && t_a == 3'd3 && t_be[0] && t_d[0]) m_seen = 0;
            if (t_wr && t_a == 3'd1 && t_be[0]) m_ctrl = t_d[1:0];
            if (t_wr && t_a == 3'd2) begin
                if (t_be[0]) m_div[7:0]  = t_d[7:0];
                if (t_be[1]) m_div[15:8] = t_d[15:8];
            end
            if (t_wr && t_a == 3'd5)
                for (int i = 0; i < 4; i++) if (t_be[i]) m_scr[8*i +: 8] = t_d[8*i +: 8];
            m_tick = t_tick;
            m_ack  = t_req;
        end
    end

    always @(negedge clk1) begin
        if (run) begin
            check("ack", {31'h0, bus.WBs_ACK}, {31'h0, m_ack});
            check("rd_dat", bus.WBs_RD_DAT, m_rd);
            check("tick_o", {31'h0, tick}, {31'h0, m_tick});
            check("div_en_o", {31'h0, div_en}, {31'h0, m_ctrl[0]});
            check("irq_o", {31'h0, irq}, {31'h0, m_irq});
        end
    end

    // ---------------- bus helpers (call right after a negedge) ----------------
    task automatic drive(input logic [2:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] d);
        bus.WBs_ADR = {12'h0, a, 2'b00};
        bus.WBs_CYC = 1'b1; bus.WBs_STB = 1'b1;
        bus.WBs_WE  = we;   bus.WBs_RD  = ~we;
        bus.WBs_BYTE_STB = be; bus.WBs_WR_DAT = d;
    endtask

    task automatic idle_bus();
        bus.WBs_ADR = '0; bus.WBs_CYC = 1'b0; bus.WBs_STB = 1'b0;
        bus.WBs_WE  = 1'b0; bus.WBs_RD = 1'b0; bus.WBs_BYTE_STB = '0; bus.WBs_WR_DAT = '0;
    endtask

    task automatic access(input logic [2:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] d, output logic [31:0] rdat);
        int lat;
        bit got;
        drive(a, we, be, d);
        got = 0; lat = 0; rdat = 0;
        for (int i = 1; i <= 4 && !got; i++) begin
            @(negedge clk1);
            if (bus.WBs_ACK) begin got = 1; lat = i; rdat = bus.WBs_RD_DAT; end
        end
        check("ack_latency", lat, 1);
        idle_bus();
        @(negedge clk1);
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] unused_r;
        access(a, 1'b1, be, d, unused_r);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] r);
        access(a, 1'b0, 4'h0, 32'h0, r);
    endtask

    task automatic wait_tick();
        bit got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk1);
            if (tick) got = 1;
        end
        check("tick_wait", {31'h0, got}, 32'h1);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] r;
    logic [5:0]  pat;
    int          n_tick, first, acks;
    logic [2:0]  ra;
    logic        rwe;
    logic [3:0]  rbe;
    logic [31:0] rd_v;

    initial begin
        idle_bus();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk1);
        check("rst_ack", {31'h0, bus.WBs_ACK}, 32'h0);
        check("rst_rd_dat", bus.WBs_RD_DAT, 32'h0);
        rst = 1'b0;
        run = 1'b1;

        rd(3'd0, r);
        check("id_read", r, 32'h0000_ABCD);

        wr(3'd2, 4'b0011, 32'd2);
        wr(3'd1, 4'b0001, 32'd1);
        n_tick = 0; first = 0;
        for (int off = 2; off <= 13; off++) begin
            @(negedge clk1);
            if (tick) begin n_tick++; if (first == 0) first = off; end
        end
        check("first_tick_offset", first, 3);
        check("tick_count_window", n_tick, 4);
        wr(3'd1, 4'b0001, 32'd0);
        rd(3'd4, r);
        check("tick_cnt_read", r, 32'd4);

        wr(3'd5, 4'b1111, 32'h1234_5678);
        wr(3'd5, 4'b0010, 32'hFFFF_FFFF);
        rd(3'd5, r);
        check("scratch_byte_strobe", r, 32'h1234_FF78);

        wr(3'd2, 4'b0011, 32'd0);
        wr(3'd1, 4'b0001, 32'd3);
        repeat (3) @(negedge clk1);
        rd(3'd3, r);
        check("tick_seen_set", r, 32'd1);
        check("irq_set", {31'h0, irq}, 32'h1);
        wr(3'd3, 4'b0001, 32'd1);
        rd(3'd3, r);
        check("w1c_set_wins", r, 32'd1);
        wr(3'd1, 4'b0001, 32'd2);
        wr(3'd3, 4'b0001, 32'd1);
        check("irq_cleared", {31'h0, irq}, 32'h0);
        rd(3'd3, r);
        check("tick_seen_cleared", r, 32'd0);

        drive(3'd5, 1'b0, 4'h0, 32'h0);
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk1);
            pat = {pat[4:0], bus.WBs_ACK};
        end
        idle_bus();
        @(negedge clk1);
        check("held_stb_ack_pattern", {26'h0, pat}, 32'b010101);

        drive(3'd5, 1'b1, 4'hF, 32'hDEAD_BEEF);
        #2 idle_bus();
        acks = 0;
        repeat (3) begin @(negedge clk1); if (bus.WBs_ACK) acks++; end
        check("abort_no_ack", acks, 0);
        rd(3'd5, r);
        check("abort_no_write", r, 32'h1234_FF78);

        wr(3'd2, 4'b0011, 32'd20);
        wr(3'd1, 4'b0001, 32'd1);
        wait_tick();
        force dut.tick_cnt_q = 32'hFFFF_FFFF;
        force_seq++;
        #1 release dut.tick_cnt_q;
        @(negedge clk1);
        rd(3'd4, r);
        check("tick_cnt_wrap", r, 32'd0);
        wait_tick();
        wr(3'd4, 4'b0001, 32'd0);
        rd(3'd4, r);
        check("clear_beats_tick", r, 32'd0);

        for (int it = 0; it < 250; it++) begin
            ra   = 3'($urandom_range(0, 7));
            rwe  = 1'($urandom_range(0, 1));
            rbe  = 4'($urandom);
            rd_v = $urandom;
            if (ra == 3'd2) rd_v = $urandom_range(0, 5);
            if ($urandom_range(0, 7) == 0) begin
                drive(ra, rwe, rbe, rd_v);
                #2 idle_bus();
                @(negedge clk1);
            end else begin
                access(ra, rwe, rbe, rd_v, r);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk1);
        end

        wr(3'd5, 4'hF, 32'hA5A5_A5A5);
        wr(3'd2, 4'b0011, 32'd7);
        wr(3'd1, 4'b0001, 32'd3);
        repeat (4) @(negedge clk1);
        drive(3'd5, 1'b0, 4'h0, 32'h0);
        @(posedge clk1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_ack", {31'h0, bus.WBs_ACK}, 32'h0);
        check("rst_mid_rd_dat", bus.WBs_RD_DAT, 32'h0);
        check("rst_mid_div_en", {31'h0, div_en}, 32'h0);
        check("rst_mid_tick", {31'h0, tick}, 32'h0);
        idle_bus();
        @(negedge clk1);
        rst = 1'b0;
        rd(3'd1, r); check("rst_ctrl", r, 32'd0);
        rd(3'd2, r); check("rst_div", r, 32'd3);
        rd(3'd5, r); check("rst_scratch", r, 32'd0);
        rd(3'd3, r); check("rst_status", r, 32'd0);
        rd(3'd4, r); check("rst_tick_cnt", r, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
